// File: rtl/cdb_arbiter.sv
// Shares one result bus between the ALU and LSB producers. Each producer has its own FIFO, and a
// round-robin grant picks one FIFO head per cycle.
// Latency: a result accepted at edge N is broadcast at edge N+1 at the earliest. There is no bypass.
// Backpressure: out_X_ready drops while that FIFO is full, during a misbranch, or while rdy is low.
// Optional stats counters are enabled with `define CDB_ARB_STATS_EN.
module cdb_arbiter #(
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              in_rob_misbranch,
  input  logic [TAG_W-1:0]  in_alu_tag,
  input  logic [DATA_W-1:0] in_alu_value,
  output logic              out_alu_ready,
  input  logic [TAG_W-1:0]  in_lsb_tag,
  input  logic [DATA_W-1:0] in_lsb_value,
  output logic              out_lsb_ready,
  output logic [TAG_W-1:0]  out_cdb_tag,
  output logic [DATA_W-1:0] out_cdb_value
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]       out_stat_alu_grants,
  output logic [31:0]       out_stat_lsb_grants,
  output logic [31:0]       out_stat_conflicts
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TAG_W-1:0] ZERO_TAG_ROB = '0;
  // Source index 0 is the ALU and index 1 is the LSB. last_grant holds that index.
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_LSB = 1'b1;

  logic [TAG_W-1:0]  src_tag  [2];
  logic [DATA_W-1:0] src_val  [2];
  logic [TAG_W-1:0]  head_tag [2];
  logic [DATA_W-1:0] head_val [2];
  logic [1:0]        src_ready;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        head_vld;
  logic              arb_en;
  logic              gsel;
  logic              last_grant;

  assign src_tag[0]    = in_alu_tag;
  assign src_val[0]    = in_alu_value;
  assign src_tag[1]    = in_lsb_tag;
  assign src_val[1]    = in_lsb_value;
  assign out_alu_ready = src_ready[0];
  assign out_lsb_ready = src_ready[1];
  assign arb_en        = rdy && !in_rob_misbranch;
  assign gsel          = pop[1];

  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [TAG_W-1:0]  tag_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] val_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;

    // Ready is based on the count before the edge, so a full FIFO refuses a push even while it pops.
    assign src_ready[s] = arb_en && (cnt < CW'(FIFO_DEPTH));
    assign push[s]      = src_ready[s] && (src_tag[s] != ZERO_TAG_ROB);
    assign head_vld[s]  = (cnt != '0);
    assign head_tag[s]  = tag_mem[rd_ptr];
    assign head_val[s]  = val_mem[rd_ptr];

    // The storage array is not reset. The count alone decides which entries are live.
    always_ff @(posedge clk) begin
      if (push[s]) begin
        tag_mem[wr_ptr] <= src_tag[s];
        val_mem[wr_ptr] <= src_val[s];
      end
    end

    // Pointer and count bookkeeping. A misbranch empties the FIFO. Pointers wrap because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else if (rdy && in_rob_misbranch) begin
        cnt    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[s]) wr_ptr <= wr_ptr + PW'(1);
        if (pop[s])  rd_ptr <= rd_ptr + PW'(1);
        case ({push[s], pop[s]})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Round-robin pick. On a tie the source not granted last time wins. Otherwise any single valid head wins.
  always_comb begin
    pop = 2'b00;
    if (arb_en) begin
      if (head_vld == 2'b11) pop = (last_grant == GRANT_LSB) ? 2'b01 : 2'b10;
      else                   pop = head_vld;
    end
  end

  // Registered broadcast. The tag lasts one cycle. The value is held while the bus is idle or frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cdb_tag   <= '0;
      out_cdb_value <= '0;
      last_grant    <= GRANT_LSB;
    end else if (rdy) begin
      if (in_rob_misbranch) begin
        out_cdb_tag <= '0;
      end else if (|pop) begin
        out_cdb_tag   <= head_tag[gsel];
        out_cdb_value <= head_val[gsel];
        last_grant    <= gsel;
      end else begin
        out_cdb_tag <= '0;
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  // Grant and conflict counters. They wrap, and they survive a misbranch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_stat_alu_grants <= '0;
      out_stat_lsb_grants <= '0;
      out_stat_conflicts  <= '0;
    end else if (arb_en) begin
      if (pop[0])             out_stat_alu_grants <= out_stat_alu_grants + 32'd1;
      if (pop[1])             out_stat_lsb_grants <= out_stat_lsb_grants + 32'd1;
      if (head_vld == 2'b11)  out_stat_conflicts  <= out_stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter.
// Inputs are driven just after the falling edge and outputs are sampled at the falling edge.
// A scoreboard queue holds the broadcasts each scenario expects, in the order they should appear.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        in_rob_misbranch;
  logic [3:0]  in_alu_tag;
  logic [31:0] in_alu_value;
  logic        out_alu_ready;
  logic [3:0]  in_lsb_tag;
  logic [31:0] in_lsb_value;
  logic        out_lsb_ready;
  logic [3:0]  out_cdb_tag;
  logic [31:0] out_cdb_value;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  logic edge_live;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rdy              (rdy),
    .in_rob_misbranch (in_rob_misbranch),
    .in_alu_tag       (in_alu_tag),
    .in_alu_value     (in_alu_value),
    .out_alu_ready    (out_alu_ready),
    .in_lsb_tag       (in_lsb_tag),
    .in_lsb_value     (in_lsb_value),
    .out_lsb_ready    (out_lsb_ready),
    .out_cdb_tag      (out_cdb_tag),
    .out_cdb_value    (out_cdb_value)
  );

  // Scoreboard monitor. It pops one expected entry for each new broadcast, meaning an edge taken with rdy=1 outside reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      edge_live = rst_n && rdy;
      @(negedge clk);
      if (edge_live && out_cdb_tag != 4'd0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got tag=%0d value=%h, expected no broadcast", out_cdb_tag, out_cdb_value);
        end else begin
          e = sb.pop_front();
          if (out_cdb_tag !== e.tag || out_cdb_value !== e.value) begin
            failures++;
            $display("FAIL sb_order got tag=%0d value=%h, expected tag=%0d value=%h",
                     out_cdb_tag, out_cdb_value, e.tag, e.value);
          end
        end
      end
    end
  end

  task automatic drive(input logic [3:0] at, input logic [31:0] av, input logic [3:0] lt, input logic [31:0] lv);
    in_alu_tag   = at;
    in_alu_value = av;
    in_lsb_tag   = lt;
    in_lsb_value = lv;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain pending=%0d required=0", sb.size());
    end
    sb.delete();
    drive(4'd0, 32'd0, 4'd0, 32'd0);
    rdy = 1'b1;
    in_rob_misbranch = 1'b0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    checks++;
    if (out_cdb_tag !== 4'd0 || out_cdb_value !== 32'd0) begin
      failures++;
      $display("FAIL reset_out got tag=%0d value=%h, expected 0/0", out_cdb_tag, out_cdb_value);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (out_cdb_tag !== 4'd0 || out_alu_ready !== 1'b1 || out_lsb_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got tag=%0d ready=%b%b, expected tag=0 ready=11",
                 i, out_cdb_tag, out_alu_ready, out_lsb_ready);
      end
    end
  endtask

  task automatic test_single;
    reset_dut;
    sb.push_back('{tag: 4'd5, value: 32'h11});
    drive(4'd5, 32'h11, 4'd0, 32'd0);
    tick;
    drive(4'd0, 32'd0, 4'd0, 32'd0);
    checks++;
    if (out_cdb_tag !== 4'd0) begin
      failures++;
      $display("FAIL single_nobypass got tag=%0d, expected 0", out_cdb_tag);
    end
    tick;
    checks++;
    if (out_cdb_tag !== 4'd5 || out_cdb_value !== 32'h11) begin
      failures++;
      $display("FAIL single_bcast got %0d/%h, expected 5/00000011", out_cdb_tag, out_cdb_value);
    end
    tick;
    checks++;
    if (out_cdb_tag !== 4'd0 || out_cdb_value !== 32'h11) begin
      failures++;
      $display("FAIL single_idle got %0d/%h, expected 0/00000011", out_cdb_tag, out_cdb_value);
    end
  endtask

  task automatic test_tie;
    reset_dut;
    sb.push_back('{tag: 4'd3, value: 32'hA});
    sb.push_back('{tag: 4'd7, value: 32'hB});
    drive(4'd3, 32'hA, 4'd7, 32'hB);
    tick;
    drive(4'd0, 32'd0, 4'd0, 32'd0);
    tick;
    checks++;
    if (out_cdb_tag !== 4'd3) begin
      failures++;
      $display("FAIL tie_first got tag=%0d, expected 3", out_cdb_tag);
    end
    tick;
    checks++;
    if (out_cdb_tag !== 4'd7) begin
      failures++;
      $display("FAIL tie_second got tag=%0d, expected 7", out_cdb_tag);
    end
    tick;
    checks++;
    if (out_cdb_tag !== 4'd0) begin
      failures++;
      $display("FAIL tie_idle got tag=%0d, expected 0", out_cdb_tag);
    end
  endtask

  // The ALU streams tags 1..4 while the LSB competes for the bus.
  // Tag 15 is shown while the ALU is not ready, so it must be dropped.
  task automatic test_back_to_back;
    logic [3:0] alu_t [9] = '{4'd1, 4'd2, 4'd3, 4'd15, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0] lsb_t [9] = '{4'd8, 4'd9, 4'd0, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       alu_r [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       lsb_r [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] out_t [9] = '{4'd0, 4'd1, 4'd8, 4'd2, 4'd9, 4'd3, 4'd10, 4'd4, 4'd0};
    reset_dut;
    for (int i = 0; i < 9; i++)
      if (out_t[i] != 4'd0)
        sb.push_back('{tag: out_t[i], value: {(out_t[i] >= 4'd8) ? 28'h0000020 : 28'h0000010, out_t[i]}});
    for (int k = 0; k < 9; k++) begin
      drive(alu_t[k], {28'h0000010, alu_t[k]}, lsb_t[k], {28'h0000020, lsb_t[k]});
      #1;
      checks++;
      if (out_alu_ready !== alu_r[k] || out_lsb_ready !== lsb_r[k]) begin
        failures++;
        $display("FAIL b2b_ready edge=%0d got alu=%b lsb=%b, expected alu=%b lsb=%b",
                 k + 1, out_alu_ready, out_lsb_ready, alu_r[k], lsb_r[k]);
      end
      tick;
      checks++;
      if (out_cdb_tag !== out_t[k]) begin
        failures++;
        $display("FAIL b2b_bcast edge=%0d got tag=%0d, expected %0d", k + 1, out_cdb_tag, out_t[k]);
      end
    end
    drive(4'd0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic test_misbranch;
    reset_dut;
    sb.push_back('{tag: 4'd1, value: 32'h1});
    drive(4'd1, 32'h1, 4'd0, 32'd0);
    tick;
    drive(4'd2, 32'h22, 4'd6, 32'h66);
    tick;
    checks++;
    if (out_cdb_tag !== 4'd1) begin
      failures++;
      $display("FAIL mis_pre got tag=%0d, expected 1", out_cdb_tag);
    end
    drive(4'd9, 32'h99, 4'd0, 32'd0);
    in_rob_misbranch = 1'b1;
    #1;
    checks++;
    if (out_alu_ready !== 1'b0 || out_lsb_ready !== 1'b0) begin
      failures++;
      $display("FAIL mis_ready got %b%b, expected 00", out_alu_ready, out_lsb_ready);
    end
    tick;
    in_rob_misbranch = 1'b0;
    drive(4'd0, 32'd0, 4'd0, 32'd0);
    #1;
    checks++;
    if (out_cdb_tag !== 4'd0 || out_alu_ready !== 1'b1 || out_lsb_ready !== 1'b1) begin
      failures++;
      $display("FAIL mis_flush got tag=%0d ready=%b%b, expected tag=0 ready=11",
               out_cdb_tag, out_alu_ready, out_lsb_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (out_cdb_tag !== 4'd0) begin
        failures++;
        $display("FAIL mis_idle cyc=%0d got tag=%0d, expected 0", i, out_cdb_tag);
      end
    end
    // The ALU was granted last before the flush, so on this tie the LSB must go first.
    sb.push_back('{tag: 4'd7, value: 32'h77});
    sb.push_back('{tag: 4'd3, value: 32'h33});
    drive(4'd3, 32'h33, 4'd7, 32'h77);
    tick;
    drive(4'd0, 32'd0, 4'd0, 32'd0);
    tick;
    checks++;
    if (out_cdb_tag !== 4'd7) begin
      failures++;
      $display("FAIL mis_lastgrant got tag=%0d, expected 7", out_cdb_tag);
    end
    tick;
    tick;
  endtask

  task automatic test_rdy_freeze;
    reset_dut;
    sb.push_back('{tag: 4'd1, value: 32'h1});
    sb.push_back('{tag: 4'd4, value: 32'h44});
    drive(4'd1, 32'h1, 4'd0, 32'd0);
    tick;
    drive(4'd4, 32'h44, 4'd0, 32'd0);
    tick;
    rdy = 1'b0;
    drive(4'd12, 32'hCC, 4'd12, 32'hCC);
    #1;
    checks++;
    if (out_alu_ready !== 1'b0 || out_lsb_ready !== 1'b0) begin
      failures++;
      $display("FAIL freeze_ready got %b%b, expected 00", out_alu_ready, out_lsb_ready);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (out_cdb_tag !== 4'd1 || out_cdb_value !== 32'h1) begin
        failures++;
        $display("FAIL freeze_hold cyc=%0d got %0d/%h, expected 1/00000001", i, out_cdb_tag, out_cdb_value);
      end
    end
    rdy = 1'b1;
    drive(4'd0, 32'd0, 4'd0, 32'd0);
    tick;
    checks++;
    if (out_cdb_tag !== 4'd4 || out_cdb_value !== 32'h44) begin
      failures++;
      $display("FAIL freeze_resume got %0d/%h, expected 4/00000044", out_cdb_tag, out_cdb_value);
    end
    tick;
    checks++;
    if (out_cdb_tag !== 4'd0) begin
      failures++;
      $display("FAIL freeze_idle got tag=%0d, expected 0", out_cdb_tag);
    end
  endtask

  task automatic test_reset_mid;
    reset_dut;
    sb.push_back('{tag: 4'd1, value: 32'h1});
    drive(4'd1, 32'h1, 4'd0, 32'd0);
    tick;
    drive(4'd2, 32'h22, 4'd5, 32'h55);
    tick;
    drive(4'd0, 32'd0, 4'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_cdb_tag !== 4'd0 || out_cdb_value !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_async got %0d/%h, expected 0/00000000", out_cdb_tag, out_cdb_value);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (out_cdb_tag !== 4'd0) begin
        failures++;
        $display("FAIL rstmid_discard cyc=%0d got tag=%0d, expected 0", i, out_cdb_tag);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rdy = 1'b1;
    in_rob_misbranch = 1'b0;
    drive(4'd0, 32'd0, 4'd0, 32'd0);
    test_reset;
    test_single;
    test_tie;
    test_back_to_back;
    test_misbranch;
    test_rdy_freeze;
    test_reset_mid;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_final pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
